// File: rtl/fifo_mac_ctrl.sv
// fifo_mac_ctrl: drains DEPTH operand pairs from FIFO A and FIFO B in lockstep,
// multiplies each pair and accumulates the products into a dot-product result.
// Pipeline: p0 = read/count control, p1 = registered product, p2 = accumulator.
// Optional build macro MAC_SATURATE_EN: clamp the accumulator at its maximum
// value instead of wrapping. ovf is sticky in both builds.
module fifo_mac_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  a_empty,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_rden,
  output logic                  b_rden,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  ovf
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic                 fire;
  logic                 start_ok;
  logic                 last_p0;
  logic [CNT_W-1:0]     cnt_p0;
  logic [PROD_W-1:0]    prod_p1;
  logic                 vld_p1;
  logic [ACC_WIDTH-1:0] acc_p2;
  logic                 ovf_p2;
  logic [ACC_WIDTH:0]   add_p2;

  // Returns {overflow, next accumulator}; the top bit is the carry out of the add.
  function automatic logic [ACC_WIDTH:0] mac_add(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [PROD_W-1:0]    prod);
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, acc} + (ACC_WIDTH + 1)'(prod);
`ifdef MAC_SATURATE_EN
    if (sum[ACC_WIDTH]) begin
      sum = {1'b1, {ACC_WIDTH{1'b1}}};
    end
`else
    // Wrap: keep the modulo sum, the carry bit still flags the overflow.
`endif
    return sum;
  endfunction

  assign fire     = (state == RUN) && !a_empty && !b_empty;
  assign start_ok = (state == IDLE) && start;
  assign last_p0  = (cnt_p0 == CNT_W'(DEPTH - 1));
  assign add_p2   = mac_add(acc_p2, prod_p1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start outside IDLE is simply not looked at.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (fire && last_p0) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; both strobes share one fire so A and B stay paired.
  always_comb begin
    a_rden = fire;
    b_rden = fire;
    busy   = (state != IDLE);
    done   = (state == DONE);
  end

  // ---- p0: pair counter ----
  always_ff @(posedge clk) begin
    if (rst || start_ok) cnt_p0 <= '0;
    else if (fire)       cnt_p0 <= cnt_p0 + 1'b1;
  end

  // ---- p1: product register; FIFO data is only valid while rden is high ----
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= fire;
      if (fire) prod_p1 <= PROD_W'(a_data) * PROD_W'(b_data);
    end
  end

  // ---- p2: accumulator and sticky overflow, cleared by an accepted start ----
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (vld_p1) begin
      acc_p2 <= add_p2[ACC_WIDTH-1:0];
      ovf_p2 <= ovf_p2 | add_p2[ACC_WIDTH];
    end
  end

  assign result = acc_p2;
  assign ovf    = ovf_p2;

endmodule

// File: tb/tb_fifo_mac_ctrl.sv
// Self-checking bench for fifo_mac_ctrl: behavioural FIFOs feed the DUT, expected
// dot products are queued at each start and compared when done pulses.
module tb_fifo_mac_ctrl;

  localparam int DW    = 8;
  localparam int DEP   = 8;
  localparam int ACC_W = 16;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  typedef struct {
    int res;
    bit ov;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             a_empty, b_empty;
  logic [DW-1:0]    a_data, b_data;
  logic             a_rden, b_rden, busy, done, ovf;
  logic [ACC_W-1:0] result;

  int   qa[$], qb[$];
  int   ma[$], mb[$];
  exp_t sb[$];
  bit   b_stall = 1'b0;

  int tests = 0, fails = 0;
  int cyc = 0, rd_cnt = 0, first_rd = -1, last_rd = -1;
  int done_cnt = 0, last_done = -1, s_cyc = 0;

  fifo_mac_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEP), .ACC_WIDTH(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_empty(a_empty), .b_empty(b_empty),
    .a_data(a_data), .b_data(b_data),
    .a_rden(a_rden), .b_rden(b_rden),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    a_empty = (qa.size() == 0);
    b_empty = (qb.size() == 0) || b_stall;
    a_data  = (qa.size() != 0) ? DW'(qa[0]) : '0;
    b_data  = (qb.size() != 0) ? DW'(qb[0]) : '0;
  endtask

  // One clock cycle: observe at negedge, pop read entries just after posedge.
  task automatic step();
    bit   ra, rb;
    exp_t e;
    drive();
    @(negedge clk);
    ra = a_rden;
    rb = b_rden;
    if (ra || rb) begin
      chk("rden_pair", rb, ra);
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (done) begin
      done_cnt++;
      last_done = cyc;
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("ovf", ovf, e.ov);
      end
    end
    @(posedge clk);
    #1;
    if (ra && qa.size() != 0) void'(qa.pop_front());
    if (rb && qb.size() != 0) void'(qb.pop_front());
    cyc++;
  endtask

  // Reference dot product over DEP entries of ma/mb starting at off.
  function automatic exp_t model(input int off);
    exp_t   e;
    longint acc, s;
    acc  = 0;
    e.ov = 1'b0;
    for (int i = 0; i < DEP; i++) begin
      s = acc + longint'(ma[off + i]) * longint'(mb[off + i]);
      if (s > ACC_MAX) begin
        e.ov = 1'b1;
`ifdef MAC_SATURATE_EN
        acc = ACC_MAX;
`else
        acc = s - (ACC_MAX + 1);
`endif
      end else begin
        acc = s;
      end
    end
    e.res = int'(acc);
    return e;
  endfunction

  task automatic do_start(input exp_t e);
    sb.push_back(e);
    rd_cnt   = 0;
    first_rd = -1;
    last_rd  = -1;
    s_cyc    = cyc;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0, k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt != n0, 1);
  endtask

  task automatic fill(input int a0, input int ainc, input int bval, input int n);
    for (int i = 0; i < n; i++) begin
      qa.push_back(a0 + i * ainc);
      qb.push_back(bval);
    end
  endtask

  initial begin
    exp_t e;
    int   d0, d1, rb0;

    // Reset
    drive();
    step();
    step();
    rst = 1'b0;
    chk("reset_outs", {a_rden, b_rden, busy, done, ovf, result}, 0);

    // Basic: A=1..8, B=2 -> 72, done at S+10
    fill(1, 1, 2, DEP);
    ma = qa; mb = qb;
    e = model(0);
    chk("basic_model", e.res, 72);
    do_start(e);
    wait_done("basic", 40);
    chk("basic_done_lat", last_done - s_cyc, 10);
    chk("basic_first_rd", first_rd - s_cyc, 1);
    chk("basic_last_rd", last_rd - s_cyc, 8);
    chk("basic_rd_cnt", rd_cnt, 8);
    chk("basic_idle", {busy, done}, 0);
    chk("basic_hold", result, 72);

    // Stall: B empty for 3 cycles after the 4th read
    fill(1, 1, 2, DEP);
    ma = qa; mb = qb;
    do_start(model(0));
    for (int k = 0; k < 20 && rd_cnt < 4; k++) step();
    b_stall = 1'b1;
    rb0 = rd_cnt;
    repeat (3) step();
    chk("stall_no_rden", rd_cnt, rb0);
    b_stall = 1'b0;
    wait_done("stall", 40);
    chk("stall_done_lat", last_done - s_cyc, 13);
    chk("stall_rd_cnt", rd_cnt, 8);

    // Overflow: all 255
    fill(255, 0, 255, DEP);
    ma = qa; mb = qb;
    e = model(0);
`ifdef MAC_SATURATE_EN
    chk("ovf_model", e.res, 65535);
`else
    chk("ovf_model", e.res, 61448);
`endif
    do_start(e);
    wait_done("ovf", 40);

    // Start while busy: pulses in RUN and DONE are ignored
    fill(1, 1, 2, DEP);
    ma = qa; mb = qb;
    do_start(model(0));
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 40 && cyc < s_cyc + 10; k++) step();
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_done_once", done_cnt - d0, 1);
    repeat (5) step();
    chk("busy_single_done", done_cnt - d0, 1);
    chk("busy_ignored", busy, 0);
    chk("busy_result_held", result, 72);

    // Reset mid-operation after 3 reads
    fill(1, 1, 2, DEP);
    do_start('{res: 0, ov: 1'b0});
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    d0 = done_cnt;
    chk("rst_mid_outs", {a_rden, b_rden, busy, done, ovf, result}, 0);
    chk("rst_mid_left_a", qa.size(), 5);
    repeat (4) step();
    chk("rst_mid_no_done", done_cnt, d0);
    ma = qa; mb = qb;
    for (int i = 0; i < 3; i++) begin
      ma.push_back(9 + i);
      mb.push_back(2);
    end
    e = model(0);
    chk("rst_mid_model", e.res, 120);
    do_start(e);
    repeat (8) step();
    chk("rst_mid_stall_rd", rd_cnt, 5);
    chk("rst_mid_stall_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      qa.push_back(9 + i);
      qb.push_back(2);
    end
    wait_done("rst_mid", 40);

    // Back-to-back: A=1..16, B=1 -> 36 then 100, done 11 cycles apart
    fill(1, 1, 1, 2 * DEP);
    ma = qa; mb = qb;
    e = model(0);
    chk("b2b_model0", e.res, 36);
    do_start(e);
    wait_done("b2b0", 40);
    d1 = last_done;
    chk("b2b_lat0", d1 - s_cyc, 10);
    e = model(DEP);
    chk("b2b_model1", e.res, 100);
    do_start(e);
    wait_done("b2b1", 40);
    chk("b2b_period", last_done - d1, DEP + 3);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_mac_ctrl.md
# fifo_mac_ctrl

Downstream consumer for a pair of FIFO instances (operand A and operand B). It drains exactly DEPTH entries from each FIFO in lockstep, multiplies paired entries, and accumulates the products into a dot-product result. It handles stalls caused by empty FIFOs and reports completion with a one-cycle done pulse. It sits directly after the FIFO stage in the minilab datapath. It relies on the FIFO driving o_data combinationally in the same cycle that rden is asserted while the FIFO is not empty.

## Interface
- DATA_WIDTH, 8, width of each FIFO data word (unsigned)
- DEPTH, 8, number of operand pairs per dot product; must be ≥1
- ACC_WIDTH, 24, accumulator and result width; must be ≥ 2*DATA_WIDTH
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset, sampled on posedge clk
- start  in  1  request a new dot product; accepted only in IDLE
- a_empty  in  1  empty flag of FIFO A
- b_empty  in  1  empty flag of FIFO B
- a_data  in  DATA_WIDTH  FIFO A o_data, valid in the same cycle as a_rden
- b_data  in  DATA_WIDTH  FIFO B o_data, valid in the same cycle as b_rden
- a_rden  out  1  read strobe to FIFO A
- b_rden  out  1  read strobe to FIFO B
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- result  out  ACC_WIDTH  accumulated sum
- ovf  out  1  sticky overflow flag for the current operation

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 clears acc, cnt, ovf, and prod_vld, then moves to RUN.
- RUN: fire = !a_empty && !b_empty. The block drives a_rden = b_rden = fire combinationally, and it is never high outside RUN.
- On fire:
  - prod <= a_data*b_data (unsigned, 2*DATA_WIDTH bits).
  - prod_vld <= 1.
  - cnt++.
- With no fire, prod_vld <= 0 and nothing else changes (stall).
- One FIFO empty means neither FIFO is read, so A and B stay paired.
- Every cycle with prod_vld=1: acc <= acc + zero-extended prod.
- RUN → DRAIN on the fire where cnt == DEPTH-1.
- DRAIN: lasts one cycle and absorbs the final product, then → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- result is driven by acc. It is final in the DONE cycle and is held through IDLE until the next accepted start clears it.
- start in RUN, DRAIN, or DONE is ignored; it is not queued.
- cnt width is clog2(DEPTH+1).
- Reset: state=IDLE, acc=0, cnt=0, prod=0, prod_vld=0, ovf=0. Outputs after reset are a_rden=0, b_rden=0, busy=0, done=0, result=0, ovf=0.
- Reset mid-operation aborts with no done pulse. Entries already read are lost; the unread remainder stays in the FIFOs.

## Timing
- Start is sampled high at the edge ending cycle S. RUN begins in S+1.
- With both FIFOs holding ≥DEPTH entries and no stalls:
  - rden is high in cycles S+1 through S+DEPTH.
  - DRAIN occurs in S+DEPTH+1.
  - done is high in S+DEPTH+2.
- Each stall cycle delays done by one cycle.
- Multiply and accumulate are separate register stages; there is no combinational path from a_data or b_data to result.
- The earliest next start is the cycle after done. Back-to-back period is DEPTH+3 cycles.

## Configuration
- MAC_SATURATE_EN defined:
  - An add whose true sum exceeds 2^ACC_WIDTH-1 loads acc = 2^ACC_WIDTH-1 and sets ovf.
  - acc stays clamped for the rest of the operation.
- MAC_SATURATE_EN undefined:
  - acc wraps modulo 2^ACC_WIDTH.
  - ovf is still set, sticky, on any carry out of bit ACC_WIDTH-1.
- In both builds ovf clears on reset or on an accepted start.

## Test plan
- Basic: defaults, FIFO A = 1..8, FIFO B = all 2, pulse start → rden high for exactly 8 consecutive cycles, done in cycle S+10, result=72, ovf=0.
- Stall: same data, b_empty held high for 3 cycles after the 4th read → no rden during the stall, A/B pairing preserved, result=72, done in S+13.
- Overflow: ACC_WIDTH=16, all entries 255 → with MAC_SATURATE_EN, result=65535 and ovf=1; without it, result=61448 and ovf=1.
- Start while busy: pulse start again in RUN and in DONE → ignored, single done pulse, result unchanged until the next start issued from IDLE.
- Reset mid-op: assert rst after 3 reads → next cycle all outputs are 0 and state is IDLE, no done pulse. FIFO A still holds 5 entries; a new start stalls until 3 more entries arrive.
- Back-to-back: 16 entries per FIFO (A=1..16, B=1), start on the cycle after each done → results 36 then 100, done pulses 11 cycles apart.
